// File: rtl/adder_result_checker.sv
// Two-stage checker comparing DUV adder results against a reference adder, with run counters and first-failure capture.
// Define CHECKER_STOP_ON_ERR_EN to end a run early once the first mismatch retires.
module adder_result_checker #(
  parameter int n         = 128,
  parameter int file_size = 30000,
  parameter int cnt_w     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic             cin,
  input  logic [n-1:0]     a,
  input  logic [n-1:0]     b,
  input  logic [n-1:0]     s_ref,
  input  logic             cout_ref,
  input  logic [n-1:0]     s_duv,
  input  logic             cout_duv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [cnt_w-1:0] vec_cnt,
  output logic [cnt_w-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [cnt_w-1:0] first_err_idx,
  output logic [n-1:0]     first_err_a,
  output logic [n-1:0]     first_err_b,
  output logic             first_err_cin,
  output logic [n:0]       first_err_syn
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [cnt_w-1:0] fs      = cnt_w'(file_size);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);
  localparam logic [cnt_w-1:0] cnt_max = '1;

  state_t           state;
  logic [cnt_w-1:0] acc_cnt;
  logic             s1_vld, s2_vld;

  logic [n-1:0]     s1_a, s1_b, s1_s_ref, s1_s_duv;
  logic             s1_cin, s1_cout_ref, s1_cout_duv;
  logic [cnt_w-1:0] s1_idx, s2_idx;
  logic [n-1:0]     s2_a, s2_b;
  logic             s2_cin;
  logic [n:0]       s2_syn;

  logic accept, last_accept, run_full, retire, retire_err, stop_now;

  always_comb begin
    accept      = valid_in && (state == RUN) && (acc_cnt < fs);
    last_accept = accept && (acc_cnt == fs - cnt_one);
    run_full    = (acc_cnt >= fs);
    retire      = s2_vld;
    retire_err  = s2_vld && (s2_syn != '0);
`ifdef CHECKER_STOP_ON_ERR_EN
    stop_now    = retire_err && !first_err_valid;
`else
    stop_now    = 1'b0;
`endif
  end

  // Datapath registers carry no reset; their valid bits gate every use.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a        <= a;
      s1_b        <= b;
      s1_cin      <= cin;
      s1_s_ref    <= s_ref;
      s1_s_duv    <= s_duv;
      s1_cout_ref <= cout_ref;
      s1_cout_duv <= cout_duv;
      s1_idx      <= acc_cnt;
    end
    if (s1_vld) begin
      s2_a   <= s1_a;
      s2_b   <= s1_b;
      s2_cin <= s1_cin;
      s2_idx <= s1_idx;
      s2_syn <= {s1_cout_ref ^ s1_cout_duv, s1_s_ref ^ s1_s_duv};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      acc_cnt         <= '0;
      s1_vld          <= 1'b0;
      s2_vld          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      vec_cnt         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
      first_err_syn   <= '0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
      if (accept) acc_cnt <= acc_cnt + cnt_one;

      if (retire) begin
        vec_cnt <= vec_cnt + cnt_one;
        if (retire_err) begin
          if (err_cnt != cnt_max) err_cnt <= err_cnt + cnt_one;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= s2_idx;
            first_err_a     <= s2_a;
            first_err_b     <= s2_b;
            first_err_cin   <= s2_cin;
            first_err_syn   <= s2_syn;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          // Pipeline is empty here, so clearing cannot race a retire.
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            acc_cnt         <= '0;
            vec_cnt         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
            first_err_syn   <= '0;
          end
        end
        RUN: begin
          if (last_accept || run_full || stop_now) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_vld && !s2_vld) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench: two checkers (file_size 4 and 10) share random stimulus; a run-level model predicts every retire and verdict.
module tb_adder_result_checker;
  localparam int N   = 128;
  localparam int CW  = 32;
  localparam int FS0 = 4;
  localparam int FS1 = 10;
`ifdef CHECKER_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct packed {
    logic cin; logic [N-1:0] a; logic [N-1:0] b;
    logic [N-1:0] s_ref; logic [N-1:0] s_duv; logic cout_ref; logic cout_duv;
  } vec_t;
  typedef struct packed { logic [CW-1:0] vec; logic [CW-1:0] err; logic fev; logic [CW-1:0] fidx; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, valid_in = 1'b0, cin = 1'b0, cout_ref = 1'b0, cout_duv = 1'b0;
  logic [N-1:0] a = '0, b = '0, s_ref = '0, s_duv = '0;
  logic busy [2], done [2], pass [2], fev [2], fcin [2];
  logic [CW-1:0] vcnt [2], ecnt [2], fidx [2];
  logic [N-1:0] fa [2], fb [2];
  logic [N:0] fsyn [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    adder_result_checker #(.n(N), .file_size((g == 0) ? FS0 : FS1), .cnt_w(CW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .cin(cin), .a(a), .b(b),
      .s_ref(s_ref), .cout_ref(cout_ref), .s_duv(s_duv), .cout_duv(cout_duv),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .vec_cnt(vcnt[g]), .err_cnt(ecnt[g]),
      .first_err_valid(fev[g]), .first_err_idx(fidx[g]), .first_err_a(fa[g]), .first_err_b(fb[g]),
      .first_err_cin(fcin[g]), .first_err_syn(fsyn[g]));
  end

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0, checks = 0;

  // Run-level reference: which offered vectors count, running totals, first failure.
  int   fsz [2] = '{FS0, FS1};
  bit   inprog [2], mseen [2];
  int   macc [2], merr [2], medge [2], mfidx [2], exp_done_edge [2];
  vec_t mfirst [2];
  exp_t expq [2][$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic c);
    vec_t x;
    logic [N:0] sum;
    sum = {1'b0, aa} + {1'b0, bb} + {{N{1'b0}}, c};
    x.cin = c; x.a = aa; x.b = bb;
    x.s_ref = sum[N-1:0]; x.cout_ref = sum[N];
    x.s_duv = x.s_ref; x.cout_duv = x.cout_ref;
    return x;
  endfunction

  task automatic model(input bit v, input bit st, input bit r, input vec_t x, input int t);
    exp_t e;
    bit mis;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        expq[d].delete();
        inprog[d] = 0;
      end else begin
        // Stop mode: acceptance ends two cycles after the first bad vector was accepted.
        if (inprog[d] && v && macc[d] < fsz[d] && (!STOP || !mseen[d] || t <= medge[d] + 2)) begin
          mis = (x.s_ref != x.s_duv) || (x.cout_ref != x.cout_duv);
          if (mis) begin
            merr[d]++;
            if (!mseen[d]) begin
              mseen[d] = 1; mfidx[d] = macc[d]; mfirst[d] = x; medge[d] = t;
            end
          end
          macc[d]++;
          exp_done_edge[d] = t + 3;
          e.vec = CW'(macc[d]); e.err = CW'(merr[d]); e.fev = mseen[d]; e.fidx = CW'(mfidx[d]);
          expq[d].push_back(e);
        end
        if (st && !inprog[d]) begin
          inprog[d] = 1; macc[d] = 0; merr[d] = 0; mseen[d] = 0; mfidx[d] = 0; medge[d] = -100;
        end
      end
    end
  endtask

  task automatic step(input bit v, input bit st, input vec_t x, input bit r);
    @(negedge clk);
    rst = r; start = st; valid_in = v;
    cin = x.cin; a = x.a; b = x.b; s_ref = x.s_ref; s_duv = x.s_duv;
    cout_ref = x.cout_ref; cout_duv = x.cout_duv;
    model(v, st, r, x, edge_cnt + 1);
  endtask

  task automatic wait_done();
    int k;
    vec_t z;
    z = mkvec('0, '0, 1'b0);
    k = 0;
    while (!(done[0] === 1'b1 && done[1] === 1'b1) && k < 60) begin
      step(0, 0, z, 0);
      k++;
    end
    check("done_timeout", k < 60, 1'b1);
    inprog[0] = 0; inprog[1] = 0;
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d_reset_outputs", d),
            {busy[d], done[d], pass[d], vcnt[d], ecnt[d], fev[d], fidx[d], fa[d], fb[d], fcin[d], fsyn[d]}, '0);
  endtask

  // Monitor: every vec_cnt step is one retire to be matched against the scoreboard.
  logic [CW-1:0] prev_v [2];
  logic prev_d [2];
  exp_t me;
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (vcnt[d] !== prev_v[d] && vcnt[d] !== '0 && !$isunknown(vcnt[d])) begin
        if (expq[d].size() == 0) begin
          check($sformatf("d%0d_unexpected_retire", d), vcnt[d], prev_v[d]);
        end else begin
          me = expq[d].pop_front();
          check($sformatf("d%0d_vec_cnt", d), vcnt[d], me.vec);
          check($sformatf("d%0d_err_cnt", d), ecnt[d], me.err);
          check($sformatf("d%0d_first_err_valid", d), fev[d], me.fev);
          if (me.fev) check($sformatf("d%0d_first_err_idx", d), fidx[d], me.fidx);
        end
      end
      prev_v[d] = vcnt[d];
      if (done[d] === 1'b1 && prev_d[d] !== 1'b1) begin
        check($sformatf("d%0d_done_edge", d), edge_cnt, exp_done_edge[d]);
        check($sformatf("d%0d_pass", d), pass[d], merr[d] == 0);
        check($sformatf("d%0d_final_vec_cnt", d), vcnt[d], macc[d]);
        check($sformatf("d%0d_pending_retires", d), expq[d].size(), 0);
        check($sformatf("d%0d_final_first_valid", d), fev[d], mseen[d]);
        if (mseen[d]) begin
          check($sformatf("d%0d_first_a", d), fa[d], mfirst[d].a);
          check($sformatf("d%0d_first_b", d), fb[d], mfirst[d].b);
          check($sformatf("d%0d_first_cin", d), fcin[d], mfirst[d].cin);
          check($sformatf("d%0d_first_syn", d), fsyn[d],
                {mfirst[d].cout_ref ^ mfirst[d].cout_duv, mfirst[d].s_ref ^ mfirst[d].s_duv});
        end
      end
      prev_d[d] = done[d];
    end
  end

  initial begin
    vec_t z, x, bad;
    logic [N:0] bit64;
    int idx;
    z = mkvec('0, '0, 1'b0);
    bit64 = '0;
    bit64[64] = 1'b1;

    // Reset, then valid pulses in IDLE are dropped.
    step(0, 0, z, 1); step(0, 0, z, 1); step(0, 0, z, 0);
    check_reset_state();
    for (int i = 0; i < 3; i++) step(1, 0, mkvec(rnd(), rnd(), 1'b1), 0);
    step(0, 0, z, 0); step(0, 0, z, 0); step(0, 0, z, 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_idle_vec_cnt", d), vcnt[d], 0);
      check($sformatf("d%0d_idle_busy", d), busy[d], 0);
    end

    // Start with a same-cycle bad vector (must not count), then all-ones + 1 matching vectors.
    bad = mkvec(rnd(), rnd(), 1'b0);
    bad.cout_duv = ~bad.cout_duv;
    step(1, 1, bad, 0);
    for (int i = 0; i < 10; i++) step(1, 0, mkvec('1, 128'd1, 1'b0), 0);
    wait_done();
    check("d0_ones_vec_cnt", vcnt[0], 4);
    check("d0_ones_err_cnt", ecnt[0], 0);
    check("d0_ones_pass", pass[0], 1);

    // Index 2 flips sum bit 64, index 3 flips carry-out.
    step(0, 1, z, 0);
    for (int i = 0; i < 10; i++) begin
      x = mkvec(rnd(), rnd(), 1'($urandom_range(1)));
      if (i == 2) x.s_duv[64] = ~x.s_duv[64];
      if (i == 3) x.cout_duv = ~x.cout_duv;
      step(1, 0, x, 0);
    end
    wait_done();
    check("d0_flip_err_cnt", ecnt[0], 2);
    check("d0_flip_pass", pass[0], 0);
    check("d0_flip_first_idx", fidx[0], 2);
    check("d0_flip_first_syn", fsyn[0], bit64);

    // Extra vectors plus a mid-run start are ignored.
    step(0, 1, z, 0);
    for (int i = 0; i < 12; i++) step(1, i == 2, mkvec(rnd(), rnd(), 1'b1), 0);
    wait_done();
    check("d0_overrun_vec_cnt", vcnt[0], 4);
    check("d0_overrun_done", done[0], 1);

    // Reset while two vectors have retired aborts the run.
    step(0, 1, z, 0);
    for (int i = 0; i < 4; i++) step(1, 0, mkvec(rnd(), rnd(), 1'b0), 0);
    step(0, 0, z, 1);
    check("d0_pre_reset_vec_cnt", vcnt[0], 2);
    step(0, 0, z, 0);
    check_reset_state();
    step(0, 1, z, 0);
    for (int i = 0; i < 10; i++) step(1, 0, mkvec(rnd(), rnd(), 1'b0), 0);
    wait_done();
    check("d0_after_reset_vec_cnt", vcnt[0], 4);

    // Mismatch at index 1 with valid every cycle.
    step(0, 1, z, 0);
    for (int i = 0; i < 12; i++) begin
      x = mkvec(rnd(), rnd(), 1'b0);
      if (i == 1) x.s_duv[0] = ~x.s_duv[0];
      step(1, 0, x, 0);
    end
    wait_done();
    check("d1_stop_vec_cnt", vcnt[1], STOP ? 4 : 10);
    check("d1_stop_pass", pass[1], 0);

    // Random runs: sparse valid, occasional single-bit faults.
    for (int r = 0; r < 4; r++) begin
      step(0, 1, z, 0);
      for (int i = 0; i < 25; i++) begin
        x = mkvec(rnd(), rnd(), 1'($urandom_range(1)));
        if ($urandom_range(5) == 0) begin
          if ($urandom_range(1) == 1) x.cout_duv = ~x.cout_duv;
          else begin
            idx = $urandom_range(N - 1);
            x.s_duv[idx] = ~x.s_duv[idx];
          end
        end
        step($urandom_range(9) < 7, 0, x, 0);
      end
      wait_done();
    end

    step(0, 0, z, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Synthesizable result checker that sits directly downstream of the adder under test and the reference adder in the adder benches.
- Each cycle it takes one operand set (cin, a, b) plus both results (s_ref/cout_ref, s_duv/cout_duv) and compares them through a 2-stage pipeline.
- Counts vectors and mismatches, captures the first failing vector, and gives a pass/fail verdict after a programmed number of vectors.
- Replaces per-vector software comparison, so long random runs (30000 vectors) can be checked in hardware or in gate-level simulation.

Parameters:
- n, 128, operand/sum width in bits
- file_size, 30000, number of vectors per run before the verdict
- cnt_w, 32, width of vector/error counters; must hold file_size

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a run
- valid_in  input  1  current cin/a/b/s_*/cout_* form a vector
- cin  input  1  carry-in applied to both adders
- a  input  n  operand A
- b  input  n  operand B
- s_ref  input  n  reference sum
- cout_ref  input  1  reference carry-out
- s_duv  input  n  DUV sum
- cout_duv  input  1  DUV carry-out
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- pass  output  1  valid only when done; 1 means err_cnt==0
- vec_cnt  output  cnt_w  vectors retired this run
- err_cnt  output  cnt_w  mismatching vectors this run; saturates
- first_err_valid  output  1  a first mismatch has been captured
- first_err_idx  output  cnt_w  0-based index of the first mismatching vector
- first_err_a  output  n  A of the first mismatch
- first_err_b  output  n  B of the first mismatch
- first_err_cin  output  1  cin of the first mismatch
- first_err_syn  output  n+1  {cout_ref^cout_duv, s_ref^s_duv} of the first mismatch

Behaviour:
- Reset:
  - All outputs 0, FSM = IDLE, pipeline valid bits cleared.
  - Reset mid-run aborts the run; no partial verdict.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start → RUN.
  - RUN: accepted vector count reaching file_size → DRAIN.
  - DRAIN: both pipeline stages empty → DONE.
  - DONE: start → RUN.
- Run start:
  - On entering RUN, clear vec_cnt, err_cnt, first_err_*, and the internal accept counter.
  - start while in RUN or DRAIN is ignored.
- Acceptance:
  - A vector is accepted when valid_in=1, the state is RUN, and accepted count < file_size.
  - valid_in outside RUN, and any vector beyond file_size, is dropped.
  - The accepted vector is still retired if rst is not asserted.
  - No backpressure: valid_in may be high every cycle.
- Pipeline:
  - Stage 1 registers all inputs of an accepted vector.
  - Stage 2 registers the syndrome {cout_ref^cout_duv, s_ref^s_duv} together with a, b, cin and the index.
  - Retire happens in the cycle after stage 2 loads. A vector accepted at edge k updates vec_cnt at edge k+2.
- Retire:
  - vec_cnt increments by 1.
  - If the syndrome is non-zero, err_cnt increments; it stops at all ones rather than wrapping.
  - If first_err_valid=0, the first_err_* fields are loaded and first_err_valid set to 1.
  - Later mismatches never overwrite the captured fields.
- Verdict:
  - done and pass update in the same cycle the FSM enters DONE.
  - pass = (err_cnt==0), frozen until the next start or rst.
- Concurrent events:
  - start and valid_in in the same cycle from IDLE or DONE: that vector is not accepted; acceptance begins the cycle after the RUN state is entered.
  - rst has priority over all other inputs.
- Boundary:
  - file_size=1: DONE is reached 3 cycles after the single accept.
  - The counter comparison uses the full cnt_w width; no wrap is allowed in the accept counter.

Optional Feature:
- Macro: CHECKER_STOP_ON_ERR_EN.
- When defined:
  - On the first mismatch retire, RUN → DRAIN immediately and acceptance stops.
  - Vectors already in the pipeline are still retired and counted; err_cnt may therefore exceed 1.
  - Verdict is pass=0.
- When undefined: the run always completes file_size vectors.

Test Plan:
- rst then idle: all outputs 0; valid_in pulses in IDLE → vec_cnt stays 0, busy=0.
- file_size=4, start, 4 back-to-back matching vectors (a=0xFF..FF, b=1, cin=0, sums equal) → done 3 cycles after last accept; vec_cnt=4, err_cnt=0, pass=1.
- file_size=4, vector index 2 has s_duv bit 64 flipped and vector 3 has cout_duv flipped:
  - err_cnt=2, pass=0, first_err_idx=2.
  - first_err_syn = only bit 64 set.
  - first_err_a/b/cin match vector 2.
- file_size=4, 6 vectors offered, plus start pulsed mid-run → exactly 4 retired, start ignored, done=1.
- Reset asserted while vec_cnt=2 → next cycle all outputs 0, state IDLE; a new start plus 4 vectors gives vec_cnt=4.
- With CHECKER_STOP_ON_ERR_EN, file_size=10, mismatch at index 1, valid every cycle:
  - Vectors 0–3 are accepted before the stop takes effect.
  - Vector 1 mismatches; err_cnt counts only those of vectors 0–3 that mismatch.
  - pass=0, vec_cnt=4.
- Without CHECKER_STOP_ON_ERR_EN, same stimulus: vec_cnt=10.
